// File: rtl/risc_bus_pkg.sv
// Shared types for the memory/register bus arbiter.
// Also supplies default bus widths when the build does not define them.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package risc_bus_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    typedef enum logic {OWN_DBG, OWN_CPU} owner_t;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way picker: a lone requester wins; on a tie the master
// that did not own the previous transaction wins.
module arb_rr_pick
    import risc_bus_pkg::*;
(
    input  logic   req_dbg,
    input  logic   req_cpu,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);
    assign grant_valid = req_dbg | req_cpu;

    always_comb begin
        grant_owner = OWN_DBG;
        if (req_dbg && req_cpu)
            grant_owner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
        else if (req_cpu)
            grant_owner = OWN_CPU;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (debug, core) to one-target bus arbiter, IDLE -> BUSY -> DONE per transaction.
// Optional ARB_TIMEOUT_EN forces completion of a BUSY that outlives TIMEOUT_CYCLES.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mem_bus_arbiter
    import risc_bus_pkg::*;
#(
    parameter int ADDR_W         = `ADDR_SIZE,
    parameter int DATA_W         = `WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Halt,
    input  logic              Dbg_cs,
    input  logic              Dbg_we,
    input  logic [ADDR_W-1:0] Dbg_addr,
    input  logic [DATA_W-1:0] Dbg_wdata,
    output logic [DATA_W-1:0] Dbg_rdata,
    output logic              Dbg_ack,
    input  logic              Cpu_cs,
    input  logic              Cpu_we,
    input  logic [ADDR_W-1:0] Cpu_addr,
    input  logic [DATA_W-1:0] Cpu_wdata,
    output logic [DATA_W-1:0] Cpu_rdata,
    output logic              Cpu_ack,
    output logic              Mem_cs,
    output logic              Mem_we,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_ack,
    output logic              Timeout_err
);
    arb_state_t        state;
    owner_t            owner, last_owner, grant_owner;
    logic              grant_valid, timed_out, finish;
    logic [DATA_W-1:0] rd_val;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Halt only masks new core grants; an in-flight core transaction runs on.
    arb_rr_pick u_pick (
        .req_dbg     (Dbg_cs),
        .req_cpu     (Cpu_cs & ~Halt),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] busy_cnt;
    logic             timeout_err_q;

    // A real ack in the final cycle takes precedence over the forced finish.
    assign timed_out = (state == BUSY) && !Mem_ack &&
                       (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            busy_cnt <= (state == BUSY) ? busy_cnt + 1'b1 : '0;
            if (timed_out)
                timeout_err_q <= 1'b1;
        end
    end
    assign Timeout_err = timeout_err_q;
`else
    assign timed_out   = 1'b0;
    assign Timeout_err = 1'b0;
`endif

    assign finish = Mem_ack | timed_out;
    assign rd_val = Mem_ack ? Mem_rdata : DATA_W'(TIMEOUT_RDATA);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            owner      <= OWN_DBG;
            last_owner <= OWN_CPU;
            Mem_cs     <= 1'b0;
            Mem_we     <= 1'b0;
            Mem_addr   <= '0;
            Mem_wdata  <= '0;
            Dbg_ack    <= 1'b0;
            Cpu_ack    <= 1'b0;
            Dbg_rdata  <= '0;
            Cpu_rdata  <= '0;
        end else begin
            Dbg_ack <= 1'b0;
            Cpu_ack <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    owner  <= grant_owner;
                    Mem_cs <= 1'b1;
                    state  <= BUSY;
                    if (grant_owner == OWN_CPU) begin
                        Mem_we    <= Cpu_we;
                        Mem_addr  <= Cpu_addr;
                        Mem_wdata <= Cpu_wdata;
                    end else begin
                        Mem_we    <= Dbg_we;
                        Mem_addr  <= Dbg_addr;
                        Mem_wdata <= Dbg_wdata;
                    end
                end
                BUSY: if (finish) begin
                    if (!Mem_we) begin
                        if (owner == OWN_CPU) Cpu_rdata <= rd_val;
                        else                  Dbg_rdata <= rd_val;
                    end
                    if (owner == OWN_CPU) Cpu_ack <= 1'b1;
                    else                  Dbg_ack <= 1'b1;
                    Mem_cs     <= 1'b0;
                    Mem_we     <= 1'b0;
                    last_owner <= owner;
                    state      <= DONE;
                end
                // DONE evaluates no grant so the owner's lingering cs is not re-served.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus
// randomized masters/target, all checked every cycle against a behavioural model.
module tb_mem_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst, Halt;
    logic          Dbg_cs, Dbg_we, Cpu_cs, Cpu_we, Mem_ack;
    logic [AW-1:0] Dbg_addr, Cpu_addr;
    logic [DW-1:0] Dbg_wdata, Cpu_wdata, Mem_rdata;
    logic [DW-1:0] Dbg_rdata, Cpu_rdata, Mem_wdata;
    logic [AW-1:0] Mem_addr;
    logic          Dbg_ack, Cpu_ack, Mem_cs, Mem_we, Timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Halt(Halt),
        .Dbg_cs(Dbg_cs), .Dbg_we(Dbg_we), .Dbg_addr(Dbg_addr), .Dbg_wdata(Dbg_wdata),
        .Dbg_rdata(Dbg_rdata), .Dbg_ack(Dbg_ack),
        .Cpu_cs(Cpu_cs), .Cpu_we(Cpu_we), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
        .Cpu_rdata(Cpu_rdata), .Cpu_ack(Cpu_ack),
        .Mem_cs(Mem_cs), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .Mem_rdata(Mem_rdata), .Mem_ack(Mem_ack), .Timeout_err(Timeout_err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: bus is either free, carrying one transfer, or in its ack cycle.
    bit          m_busy, m_done, m_cpu_owns, m_last_cpu;
    bit          m_cs, m_we, m_dack, m_cack, m_terr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_drd, m_crd;
    int          m_wait;

    logic          m_cpu_elig, m_elig, m_pick_cpu, m_fin;
    logic [DW-1:0] m_rd_val;
    assign m_cpu_elig = Cpu_cs && !Halt;
    assign m_elig     = Dbg_cs || m_cpu_elig;
    assign m_pick_cpu = m_cpu_elig && !(Dbg_cs && m_last_cpu);
    assign m_fin      = Mem_ack || (TO_EN && m_wait == TO - 1);
    assign m_rd_val   = Mem_ack ? Mem_rdata : 32'hDEAD_BEEF;

    always @(posedge Clk) begin
        if (Rst) begin
            m_busy <= 0; m_done <= 0; m_cpu_owns <= 0; m_last_cpu <= 1;
            m_cs <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0;
            m_drd <= '0; m_crd <= '0; m_dack <= 0; m_cack <= 0; m_terr <= 0; m_wait <= 0;
        end else begin
            m_dack <= 0;
            m_cack <= 0;
            if (m_done) begin
                m_done <= 0;
            end else if (m_busy) begin
                if (m_fin) begin
                    m_busy <= 0; m_done <= 1; m_cs <= 0; m_we <= 0;
                    m_last_cpu <= m_cpu_owns;
                    if (m_cpu_owns) m_cack <= 1; else m_dack <= 1;
                    if (!m_we) begin
                        if (m_cpu_owns) m_crd <= m_rd_val; else m_drd <= m_rd_val;
                    end
                    if (!Mem_ack) m_terr <= 1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (m_elig) begin
                m_busy <= 1; m_cs <= 1; m_wait <= 0; m_cpu_owns <= m_pick_cpu;
                m_we    <= m_pick_cpu ? Cpu_we    : Dbg_we;
                m_addr  <= m_pick_cpu ? Cpu_addr  : Dbg_addr;
                m_wdata <= m_pick_cpu ? Cpu_wdata : Dbg_wdata;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("mem_cs", Mem_cs, m_cs);
            check("mem_we", Mem_we, m_we);
            check("mem_addr", Mem_addr, m_addr);
            check("mem_wdata", Mem_wdata, m_wdata);
            check("dbg_ack", Dbg_ack, m_dack);
            check("cpu_ack", Cpu_ack, m_cack);
            check("dbg_rdata", Dbg_rdata, m_drd);
            check("cpu_rdata", Cpu_rdata, m_crd);
            check("timeout_err", Timeout_err, m_terr);
        end
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1; Dbg_cs = 0; Cpu_cs = 0; Mem_ack = 0;
        cyc(); cyc();
        Rst = 0;
    endtask

    initial begin
        Rst = 1; Halt = 0; Dbg_cs = 0; Dbg_we = 0; Dbg_addr = '0; Dbg_wdata = '0;
        Cpu_cs = 0; Cpu_we = 0; Cpu_addr = '0; Cpu_wdata = '0;
        Mem_ack = 0; Mem_rdata = '0;
        cyc(); cyc();
        chk_en = 1;

        // Reset values
        check("rst mem_cs", Mem_cs, 0);
        check("rst mem_addr", Mem_addr, 0);
        check("rst acks", {Dbg_ack, Cpu_ack}, 0);
        check("rst rdata", {Dbg_rdata, Cpu_rdata}, 0);
        check("rst timeout_err", Timeout_err, 0);

        // Halted: debug write, Mem_ack in cycle 2
        Rst = 0; Halt = 1;
        Dbg_cs = 1; Dbg_we = 1; Dbg_addr = 16'h0010; Dbg_wdata = 32'h1234_5678;
        cyc();
        check("A cs c1", Mem_cs, 1);
        check("A addr c1", Mem_addr, 16'h0010);
        check("A we c1", Mem_we, 1);
        check("A wdata c1", Mem_wdata, 32'h1234_5678);
        check("A ack c1", Dbg_ack, 0);
        cyc();
        check("A cs c2", Mem_cs, 1);
        Mem_ack = 1;
        cyc();
        check("A dbg_ack c3", Dbg_ack, 1);
        check("A cpu_ack c3", Cpu_ack, 0);
        check("A cs c3", Mem_cs, 0);
        Mem_ack = 0; Dbg_cs = 0;
        cyc();
        check("A dbg_ack c4", Dbg_ack, 0);

        // Halted core read is never granted until Halt drops
        Cpu_cs = 1; Cpu_we = 0; Cpu_addr = 16'h0020; Cpu_wdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("B held cs", Mem_cs, 0);
        end
        Halt = 0;
        cyc();
        check("B cs", Mem_cs, 1);
        check("B addr", Mem_addr, 16'h0020);
        Mem_ack = 1; Mem_rdata = 32'hCAFE_F00D;
        cyc();
        check("B cpu_ack", Cpu_ack, 1);
        check("B cpu_rdata", Cpu_rdata, 32'hCAFE_F00D);
        check("B dbg_ack", Dbg_ack, 0);
        Mem_ack = 0; Cpu_cs = 0;
        cyc();

        // Both requesting continuously: DBG, CPU, DBG, CPU with 3-cycle turns
        do_reset();
        Halt = 0; Dbg_cs = 1; Dbg_we = 0; Cpu_cs = 1; Cpu_we = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check("C dbg_ack", Dbg_ack, (c % 6) == 2);
            check("C cpu_ack", Cpu_ack, (c % 6) == 5);
            Mem_ack = m_cs; Mem_rdata = 32'h100 + c;
        end
        Dbg_cs = 0; Cpu_cs = 0; Mem_ack = 0;
        cyc();

        // Reset while BUSY abandons the transfer
        do_reset();
        Halt = 1; Dbg_cs = 1; Dbg_we = 0; Dbg_addr = 16'h0030;
        cyc();
        check("D cs busy", Mem_cs, 1);
        Rst = 1;
        cyc();
        check("D cs after rst", Mem_cs, 0);
        check("D no ack", Dbg_ack, 0);
        Rst = 0;
        cyc();
        check("D regrant", Mem_cs, 1);
        Mem_ack = 1; Mem_rdata = 32'h0000_55AA;
        cyc();
        check("D dbg_ack", Dbg_ack, 1);
        check("D dbg_rdata", Dbg_rdata, 32'h0000_55AA);
        Mem_ack = 0; Dbg_cs = 0;
        cyc();

        // Halt rising mid core transfer does not preempt it
        do_reset();
        Halt = 0; Cpu_cs = 1; Cpu_we = 1; Cpu_addr = 16'h0040; Cpu_wdata = 32'hA5A5_0001;
        cyc();
        check("E cs", Mem_cs, 1);
        check("E we", Mem_we, 1);
        Halt = 1; Dbg_cs = 1; Dbg_we = 0; Dbg_addr = 16'h0050;
        cyc();
        cyc();
        Mem_ack = 1;
        cyc();
        check("E cpu_ack", Cpu_ack, 1);
        check("E dbg_ack", Dbg_ack, 0);
        Mem_ack = 0; Cpu_cs = 0;
        cyc();
        cyc();
        check("E dbg granted", Mem_cs, 1);
        check("E dbg addr", Mem_addr, 16'h0050);
        Mem_ack = 1; Mem_rdata = 32'h0BAD_CAFE;
        cyc();
        check("E dbg ack", Dbg_ack, 1);
        Mem_ack = 0; Dbg_cs = 0;
        cyc();

`ifdef ARB_TIMEOUT_EN
        // Target never acks: forced completion after TO BUSY cycles
        do_reset();
        Halt = 1; Dbg_cs = 1; Dbg_we = 0; Dbg_addr = 16'h0060;
        for (int c = 1; c <= TO; c++) begin
            cyc();
            check("F cs busy", Mem_cs, 1);
            check("F no ack yet", Dbg_ack, 0);
        end
        cyc();
        check("F dbg_ack", Dbg_ack, 1);
        check("F dbg_rdata", Dbg_rdata, 32'hDEAD_BEEF);
        check("F timeout_err", Timeout_err, 1);
        Dbg_cs = 0;
        repeat (4) cyc();
        check("F sticky", Timeout_err, 1);
        do_reset();
        cyc();
        check("F cleared", Timeout_err, 0);
`endif

        // Randomized masters and target
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (m_dack) Dbg_cs = 0;
            else if (!Dbg_cs && $urandom_range(3) == 0) begin
                Dbg_cs = 1; Dbg_we = 1'($urandom); Dbg_addr = AW'($urandom); Dbg_wdata = $urandom;
            end
            if (m_cack) Cpu_cs = 0;
            else if (!Cpu_cs && $urandom_range(2) == 0) begin
                Cpu_cs = 1; Cpu_we = 1'($urandom); Cpu_addr = AW'($urandom); Cpu_wdata = $urandom;
            end
            if ($urandom_range(15) == 0) Halt = ~Halt;
            Mem_ack   = m_cs ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            Mem_rdata = $urandom;
        end
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master, one-target arbiter for the shared memory/register bus. Masters are the debug request decoder (UART command path) and the core data port. Debug wins while the core is halted; round-robin applies otherwise. Each grant snapshots the winner's request, runs one transaction to the target, returns read data with a one-cycle ack to the owner, then releases the bus.

Parameters:
ADDR_W, `ADDR_SIZE (16), address width
DATA_W, `WORD_SIZE (32), data width
TIMEOUT_CYCLES, 255, BUSY cycles before forced completion (used only with ARB_TIMEOUT_EN)

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high
Halt  in  1  core halted (decoder Irq); 1 = CPU requests not granted
Dbg_cs / Dbg_we  in  1 / 1  debug request, write enable
Dbg_addr / Dbg_wdata  in  ADDR_W / DATA_W  debug address, write data
Dbg_rdata  out  DATA_W  debug read data (registered)
Dbg_ack  out  1  debug completion pulse
Cpu_cs / Cpu_we  in  1 / 1  core request, write enable
Cpu_addr / Cpu_wdata  in  ADDR_W / DATA_W  core address, write data
Cpu_rdata  out  DATA_W  core read data (registered)
Cpu_ack  out  1  core completion pulse
Mem_cs / Mem_we  out  1 / 1  target select, write enable
Mem_addr / Mem_wdata  out  ADDR_W / DATA_W  target address, write data
Mem_rdata  in  DATA_W  target read data
Mem_ack  in  1  target completion
Timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; Mem_cs/Mem_we 0; Mem_addr/Mem_wdata 0; Dbg_ack/Cpu_ack 0; Dbg_rdata/Cpu_rdata 0; Timeout_err 0; last_owner = CPU, so debug wins the first tie. Reset mid-transaction drops Mem_cs next edge; the transaction is abandoned and no ack is issued.
- Masters hold cs/we/addr/wdata stable until they see ack sampled with their own cs; they drop cs the cycle after ack.
- States IDLE, BUSY, DONE.
- IDLE: eligible = Dbg_cs, and Cpu_cs & ~Halt.
  - One eligible: grant it.
  - Both eligible: grant the master that is not last_owner.
  - On grant: latch owner, Mem_addr, Mem_wdata, Mem_we from that master; set Mem_cs=1; go to BUSY.
- BUSY: Mem_cs=1 and Mem_* stay constant; requester-input changes are ignored. On Mem_ack:
  - Read (~Mem_we): owner rdata <= Mem_rdata.
  - Write: owner rdata unchanged.
  - Owner ack <= 1; Mem_cs <= 0; Mem_we <= 0; last_owner <= owner; go to DONE.
- DONE: one cycle. Owner ack=1 for exactly this cycle; no grant is evaluated, so the still-high cs is not re-granted. Next state IDLE.
- Latency: request in IDLE at cycle 0 → Mem_cs at cycle 1 → Mem_ack at cycle k ≥ 1 → owner ack at cycle k+1 → IDLE at k+2. Minimum 3 cycles per transaction.
- Halt rising during a CPU BUSY: no preemption; the transaction completes. Halt only masks new CPU grants.
- The non-owner's ack is always 0. rdata holds its last value until overwritten by that owner's next read.
- Mem_ack outside BUSY is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: 8-bit-or-wider cycle counter, cleared on BUSY entry, increments each BUSY cycle. At count == TIMEOUT_CYCLES-1 with no Mem_ack:
  - Forced completion into DONE.
  - Read: owner rdata <= 32'hDEAD_BEEF; write: rdata unchanged.
  - Timeout_err <= 1, sticky until Rst.
  - Mem_ack in the same cycle wins over timeout.
- Undefined: no counter; BUSY waits indefinitely; Timeout_err tied 0.

Decomposition:
- Package risc_bus_pkg:
  - arb_state_t {IDLE, BUSY, DONE}
  - owner_t {OWN_DBG, OWN_CPU}
  - TIMEOUT_RDATA = 32'hDEAD_BEEF
- Sub-module arb_rr_pick: combinational 2-way picker (req_dbg, req_cpu, last_owner → grant_valid, grant_owner). Instantiated once.

Test Plan:
- Halt=1, Dbg_cs write addr 8'h10 wdata 32'h1234_5678, Mem_ack at cycle 2 → Mem_cs cycles 1-2, Mem_addr 16'h0010, Mem_we=1, Dbg_ack only at cycle 3, Cpu_ack 0.
- Halt=1, Cpu_cs read held 20 cycles → Mem_cs never asserts for CPU. Drop Halt → CPU granted next IDLE cycle; Mem_rdata 32'hCAFE_F00D → Cpu_rdata 32'hCAFE_F00D with Cpu_ack.
- Halt=0, both cs asserted continuously after reset → grants alternate DBG, CPU, DBG, CPU; each ack is one cycle; no back-to-back double grant.
- Reset asserted while BUSY → next cycle Mem_cs=0, no ack, state IDLE; a new debug request is then granted normally.
- Halt=0, CPU BUSY, Halt rises mid-transaction → CPU transaction completes with Cpu_ack. A pending Dbg_cs is granted next.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, debug read with Mem_ack never asserted → Dbg_ack after 8 BUSY cycles, Dbg_rdata 32'hDEAD_BEEF, Timeout_err=1 until Rst.
